// File: rtl/key_event_scheduler.sv
// Frame-rate key debouncer and round-robin note event arbiter.
// Publishes a tear-free pressed mask and a valid/ready note channel.
module key_event_scheduler #(
  parameter int NUM_KEYS    = 8,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vsync_pulse,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                note_ready,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic                note_valid,
  output logic [2:0]          note_idx,
  output logic                note_on,
  output logic [NUM_KEYS-1:0] pending_mask
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_FRAMES - 1);

  state_t state, state_d;

  logic [3:0] cnt   [NUM_KEYS];
  logic [3:0] cnt_d [NUM_KEYS];

  logic [NUM_KEYS-1:0] pressed_d;
  logic [NUM_KEYS-1:0] trans;
  logic [NUM_KEYS-1:0] dir;
  logic [NUM_KEYS-1:0] dir_d;
  logic [NUM_KEYS-1:0] pend_d;
  logic [NUM_KEYS-1:0] sel;

  logic [7:0] pend8;
  logic [7:0] dir8;
  logic [3:0] j;
  logic [2:0] rr_ptr;
  logic [2:0] rr_d;
  logic [2:0] idx_d;
  logic [2:0] pick;
  logic       found;
  logic       valid_d;
  logic       on_d;

  assign pend8 = 8'(pending_mask);
  assign dir8  = 8'(dir);

  always_comb begin
    pressed_d = key_pressed;
    trans     = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt[k];
      if (vsync_pulse) begin
        if (key_raw[k] == key_pressed[k]) begin
          cnt_d[k] = '0;
        end else if (cnt[k] == HOLD_LAST) begin
          pressed_d[k] = key_raw[k];
          cnt_d[k]     = '0;
          trans[k]     = 1'b1;
        end else begin
          cnt_d[k] = cnt[k] + 4'd1;
        end
      end
    end
  end

  // First pending key at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    j     = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      j = {1'b0, rr_ptr} + 4'(i);
      if (j >= 4'(NUM_KEYS)) j = j - 4'(NUM_KEYS);
      if (!found && pend8[j[2:0]]) begin
        found = 1'b1;
        pick  = j[2:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    valid_d = note_valid;
    idx_d   = note_idx;
    on_d    = note_on;
    rr_d    = rr_ptr;
    sel     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          sel     = NUM_KEYS'(1) << pick;
          valid_d = 1'b1;
          idx_d   = pick;
          on_d    = dir8[pick];
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (note_ready) begin
          valid_d = 1'b0;
          rr_d    = (note_idx == 3'(NUM_KEYS - 1)) ?
                    3'd0 : note_idx + 3'd1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // A second transition before issue cancels the first.
  always_comb begin
    pend_d = pending_mask & ~sel;
    dir_d  = dir;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (trans[k]) begin
        if (pend_d[k]) begin
          pend_d[k] = 1'b0;
        end else begin
          pend_d[k] = 1'b1;
          dir_d[k]  = pressed_d[k];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      key_pressed  <= '0;
      pending_mask <= '0;
      dir          <= '0;
      note_valid   <= 1'b0;
      note_idx     <= '0;
      note_on      <= 1'b0;
      rr_ptr       <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
    end else begin
      state        <= state_d;
      key_pressed  <= pressed_d;
      pending_mask <= pend_d;
      dir          <= dir_d;
      note_valid   <= valid_d;
      note_idx     <= idx_d;
      note_on      <= on_d;
      rr_ptr       <= rr_d;
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= cnt_d[k];
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: directed scenarios
// followed by randomized frames against a behavioural model.
module tb_key_event_scheduler;

  localparam int N    = 8;
  localparam int HOLD = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         vsync_pulse;
  logic [N-1:0] key_raw;
  logic         note_ready;
  logic [N-1:0] key_pressed;
  logic         note_valid;
  logic [2:0]   note_idx;
  logic         note_on;
  logic [N-1:0] pending_mask;

  always #5 clock = ~clock;

  key_event_scheduler #(
    .NUM_KEYS(N),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .vsync_pulse(vsync_pulse),
    .key_raw(key_raw),
    .note_ready(note_ready),
    .key_pressed(key_pressed),
    .note_valid(note_valid),
    .note_idx(note_idx),
    .note_on(note_on),
    .pending_mask(pending_mask)
  );

  logic [N-1:0] m_press, m_pend, m_dir;
  int           m_run [N];
  bit           m_off;
  int           m_idx, m_rr;
  logic [3:0]   expq [$];

  int vectors = 0, miscompares = 0;
  int offers = 0, handshakes = 0;
  int obs_idx [$];
  bit obs_on  [$];
  bit mon_en = 0;
  logic p_valid = 1'b0;
  logic [2:0] p_idx = '0;
  logic p_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: spec rules per clock edge on abstract per-key state.
  always @(posedge clock) begin : model
    int k;
    if (reset) begin
      m_press = '0; m_pend = '0; m_dir = '0;
      m_off = 0; m_idx = 0; m_rr = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      expq.delete();
    end else begin
      if (!m_off) begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (m_pend[k]) begin
            expq.push_back({3'(k), m_dir[k]});
            m_pend[k] = 1'b0;
            m_off = 1;
            m_idx = k;
            break;
          end
        end
      end else if (note_ready) begin
        m_off = 0;
        m_rr = (m_idx + 1) % N;
      end
      if (vsync_pulse) begin
        for (int i = 0; i < N; i++) begin
          if (key_raw[i] !== m_press[i]) begin
            m_run[i]++;
            if (m_run[i] == HOLD) begin
              m_press[i] = key_raw[i];
              m_run[i] = 0;
              if (m_pend[i]) m_pend[i] = 1'b0;
              else begin
                m_pend[i] = 1'b1;
                m_dir[i] = key_raw[i];
              end
            end
          end else m_run[i] = 0;
        end
      end
    end
  end

  always @(posedge clock) begin : monitor
    logic [3:0] e;
    #1;
    if (mon_en) begin
      chk("key_pressed", 32'(key_pressed), 32'(m_press));
      chk("pending_mask", 32'(pending_mask), 32'(m_pend));
      chk("note_valid", 32'(note_valid), 32'(m_off));
      if (note_valid && !p_valid) begin
        offers++;
        obs_idx.push_back(int'(note_idx));
        obs_on.push_back(note_on);
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL offer: got idx %0d on %0b, none expected",
                   note_idx, note_on);
        end else begin
          e = expq.pop_front();
          chk("offer idx/on", 32'({note_idx, note_on}), 32'(e));
        end
      end else if (note_valid && p_valid) begin
        chk("offer stable", 32'({note_idx, note_on}), 32'({p_idx, p_on}));
      end
      if (p_valid && note_ready && !reset) handshakes++;
      p_valid = note_valid;
      p_idx = note_idx;
      p_on = note_on;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic frame(input logic [N-1:0] raw, input int gap);
    vsync_pulse = 1'b1;
    key_raw = raw;
    @(negedge clock);
    vsync_pulse = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic confirm(input logic [N-1:0] raw, input int gap);
    repeat (HOLD) frame(raw, gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic int seq_idx();
    int s = 0;
    foreach (obs_idx[i]) s = s * 16 + obs_idx[i];
    return s;
  endfunction

  function automatic int seq_on();
    int s = 0;
    foreach (obs_on[i]) s = s * 2 + int'(obs_on[i]);
    return s;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " key_pressed"}, 32'(key_pressed), 0);
    chk({tag, " pending"}, 32'(pending_mask), 0);
    chk({tag, " valid"}, 32'(note_valid), 0);
    chk({tag, " idx"}, 32'(note_idx), 0);
    chk({tag, " on"}, 32'(note_on), 0);
  endtask

  initial begin
    int o0, h0;
    logic [N-1:0] raw;
    reset = 1'b1;
    vsync_pulse = 1'b0;
    key_raw = '0;
    note_ready = 1'b0;
    tick(2);
    mon_en = 1;
    reset = 1'b0;
    chk_all_zero("reset");

    note_ready = 1'b1;
    o0 = offers;
    repeat (5) frame('0, 3);
    chk("idle offers", offers - o0, 0);
    chk_all_zero("idle");

    h0 = handshakes;
    obs_idx.delete(); obs_on.delete();
    frame(8'h04, 2);
    frame(8'h04, 2);
    chk("key2 early", 32'(key_pressed[2]), 0);
    frame(8'h04, 0);
    chk("key2 confirmed", 32'(key_pressed[2]), 1);
    tick(6);
    chk("key2 handshakes", handshakes - h0, 1);
    chk("key2 event", seq_idx() * 2 + seq_on(), 5);

    o0 = offers;
    frame(8'h14, 2);
    frame(8'h14, 2);
    frame(8'h04, 2);
    frame(8'h14, 2);
    frame(8'h14, 2);
    chk("glitch key4", 32'(key_pressed[4]), 0);
    chk("glitch offers", offers - o0, 0);

    do_reset();
    note_ready = 1'b1;
    obs_idx.delete(); obs_on.delete();
    confirm(8'h62, 1);
    tick(12);
    chk("rr order", seq_idx(), 32'h156);
    chk("rr dirs", seq_on(), 3'b111);
    obs_idx.delete(); obs_on.delete();
    confirm(8'h23, 1);
    tick(12);
    chk("rr wrap order", seq_idx(), 32'h06);
    chk("rr wrap dirs", seq_on(), 2'b10);

    do_reset();
    note_ready = 1'b0;
    obs_idx.delete(); obs_on.delete();
    h0 = handshakes;
    confirm(8'h08, 2);
    tick(3);
    chk("bp offered", 32'({note_valid, note_idx, note_on}), 32'b1_011_1);
    confirm(8'h00, 2);
    chk("bp release queued", 32'(pending_mask), 32'h08);
    confirm(8'h08, 2);
    chk("bp cancelled", 32'(pending_mask), 0);
    chk("bp still held", 32'({note_valid, note_idx}), 32'b1_011);
    note_ready = 1'b1;
    tick(10);
    chk("bp handshakes", handshakes - h0, 1);
    chk("bp events", seq_idx() * 2 + seq_on(), 7);

    do_reset();
    note_ready = 1'b0;
    confirm(8'h20, 2);
    tick(3);
    confirm(8'h32, 2);
    chk("pre-reset offer", 32'({note_valid, note_idx}), 32'b1_101);
    chk("pre-reset pending", 32'(pending_mask), 32'h12);
    h0 = handshakes;
    do_reset();
    chk_all_zero("mid-offer reset");
    chk("reset handshakes", handshakes - h0, 0);
    obs_idx.delete(); obs_on.delete();
    note_ready = 1'b1;
    confirm(8'h02, 2);
    tick(10);
    chk("post-reset handshakes", handshakes - h0, 1);
    chk("post-reset event", seq_idx() * 2 + seq_on(), 3);

    raw = '0;
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      raw = raw ^ N'($urandom & $urandom);
      note_ready = ($urandom_range(0, 3) != 0);
      frame(raw, $urandom_range(0, 4));
    end
    note_ready = 1'b1;
    tick(40);
    chk("drain queue", expq.size(), 0);
    chk("drain pending", 32'(pending_mask), 0);
    chk("drain valid", 32'(note_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Frame-rate controller between the camera-based key detector and the key sprite / audio blocks of the projected piano.
- Samples raw per-key press flags once per video frame and debounces them across frames.
- Publishes a tear-free pressed mask that the key renderers use for colour selection.
- Arbitrates press/release events from all keys round-robin onto a single valid/ready note channel to the audio synthesiser.

Parameters:
NUM_KEYS, 8, number of keys; legal range 2..8; note_idx is fixed at 3 bits.
HOLD_FRAMES, 3, consecutive frames a changed raw value must persist before the state flips; legal range 1..15.

Ports:
clock  input  1  system/pixel clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
vsync_pulse  input  1  single-cycle strobe at start of vertical blank; the only cycle key_raw is sampled
key_raw  input  NUM_KEYS  undebounced press flags from the detector; bit k = key k
note_ready  input  1  audio block accepts the event when high together with note_valid
key_pressed  output  NUM_KEYS  debounced pressed mask; changes only on the cycle after vsync_pulse
note_valid  output  1  event offered
note_idx  output  3  key index of the offered event
note_on  output  1  1 = press, 0 = release
pending_mask  output  NUM_KEYS  per-key queued-event flags (debug/visibility)

Behaviour:
- Reset: key_pressed=0, all per-key counters=0, pending_mask=0, direction bits=0, note_valid=0, note_idx=0, note_on=0, rr_ptr=0, FSM=IDLE.
- Reset asserted mid-offer drops the offered event and all pending events; no handshake completes on that cycle.
- Debounce: acts only on cycles where vsync_pulse=1. Per key k, with 4-bit counter cnt[k]:
  - key_raw[k]==key_pressed[k]: cnt[k]<=0.
  - Mismatch and cnt[k]==HOLD_FRAMES-1: key_pressed[k]<=key_raw[k]; cnt[k]<=0; raise a transition for k with dir = new value.
  - Mismatch otherwise: cnt[k]<=cnt[k]+1.
  - Net effect: a new raw value must be seen on HOLD_FRAMES consecutive vsync pulses. HOLD_FRAMES=1 gives immediate update.
- Transition queueing, per key:
  - pending[k]=0: pending[k]<=1, dir[k]<=new value.
  - pending[k]=1 (earlier event not yet issued): pending[k]<=0. The opposite-direction pair cancels; no event is ever emitted for a glitch the audio never saw.
- Arbiter FSM, two states:
  - IDLE: if pending_mask!=0, select the first set bit scanning from rr_ptr upward, wrapping modulo NUM_KEYS. Register note_idx=k, note_on=dir[k], note_valid<=1. Clear pending[k] on the same edge. Go to OFFER.
  - OFFER: note_valid, note_idx and note_on are held stable until note_ready=1. On that edge: note_valid<=0, rr_ptr<=(note_idx+1) mod NUM_KEYS, go to IDLE.
  - Minimum 2 cycles per event; note_valid is never high in IDLE.
- Simultaneity:
  - A transition on the key currently offered enqueues normally, because its pending bit was already cleared at offer time. It is emitted later in order.
  - A debounce transition and an IDLE selection on the same edge: selection uses pre-edge pending_mask. The new transition lands in pending on that edge and is seen the next time the FSM is in IDLE.
- note_ready may be held high permanently. With note_ready stuck low, events coalesce and cancel per key; nothing overflows.
- key_pressed is independent of the arbiter: the render path never stalls on audio backpressure.

Test Plan:
- Reset then idle: key_raw=0, 5 vsync pulses -> key_pressed=0, note_valid never asserts, pending_mask=0.
- Debounce, HOLD_FRAMES=3: key_raw[2]=1 held across vsync 1,2,3 -> key_pressed[2] rises the cycle after pulse 3, not earlier. note_valid=1, note_idx=2, note_on=1 the following cycle; note_ready=1 -> one handshake.
- Glitch rejection: key_raw[4]=1 for pulses 1–2, 0 at pulse 3, 1 at pulses 4–5 -> key_pressed[4] stays 0 through pulse 5, and no event is emitted.
- Round-robin, note_ready=1: keys 1, 5, 6 confirm on the same vsync with rr_ptr=0 -> events in order 1, 5, 6. Then keys 0 and 6 confirm -> order 0, 6 (rr_ptr=7 wraps to 0).
- Backpressure/cancel, note_ready=0: key 3 press confirms -> offered, held stable. Key 3 release confirms -> pending[3]=1. Key 3 press again confirms -> pending[3]=0. Raise note_ready -> exactly one handshake (idx 3, on), and no further events.
- Reset mid-offer: note_valid=1 with idx 5 and pending_mask=8'h12 -> after one reset cycle all outputs are 0. A subsequent confirmed press of key 1 is emitted as the only event.
